des_block_loader: RTL
=====================

# des_block_loader

Byte-serial front end for the DES `encryption` core. It assembles incoming bytes into a 64-bit key and 64-bit plaintext blocks and drives the core's `key` and `plainText` inputs. It holds each block stable under a valid/ready handshake until the downstream capture stage has sampled `encrypted`. It sits directly upstream of the core, between the host byte interface and the combinational DES datapath.

## Interface
- `CHECK_PARITY`, default 0: when 1, every key byte must have odd parity (DES convention); a key group with any even-parity byte is rejected.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: byte offered.
- `in_data` in 8: byte value.
- `in_is_key` in 1: sideband tag, sampled with each byte; 1 = key byte, 0 = plaintext byte.
- `in_ready` out 1: byte accepted when `in_valid && in_ready` at the rising edge.
- `abort` in 1: synchronous flush of any partial group or held block.
- `err_clear` in 1: synchronous clear of sticky error flags.
- `plain_text` out 64: connects to core `plainText`; first byte received lands in core bits 0..7 (MSB).
- `key` out 64: connects to core `key`; first key byte lands in bits 63:56.
- `key_valid` out 1: a key has been committed since reset.
- `block_valid` out 1: `plain_text` is stable and `encrypted` is meaningful.
- `block_ready` in 1: downstream has captured `encrypted`.
- `err_mismatch` out 1: sticky; tag changed inside a group.
- `err_no_key` out 1: sticky; a data block completed with no key committed.
- `err_parity` out 1: sticky; key group rejected for parity (only when `CHECK_PARITY`=1).

## Operation
- **States:**
  - IDLE: no partial group.
  - COLLECT: 1..7 bytes of the group held.
  - HOLD: data block presented.
- **Byte counter and group type:** a 3-bit byte counter and a latched group type. The first byte of a group latches the type from `in_is_key`.
- **Acceptance:** `in_ready = (state != HOLD) && !abort`.
- **Assembly:** accepted bytes shift into a 64-bit shadow register, MSB first.
- **Mismatch:** a byte whose tag differs from the latched type at index 1..7:
  - the partial group is discarded and `err_mismatch` is set;
  - that byte becomes index 0 of a new group of its own type.
- **8th key byte:**
  - The shadow is copied to `key` and `key_valid` is set to 1; return to IDLE.
  - With `CHECK_PARITY`=1 and any byte of even parity, `key` is unchanged, `err_parity` is set, and the state returns to IDLE.
- **8th data byte:**
  - If `key_valid`=1: the shadow is copied to `plain_text`, `block_valid` is set to 1, and the state enters HOLD.
  - Otherwise: the block is dropped, `err_no_key` is set, and the state returns to IDLE.
- **HOLD:**
  - `plain_text` and `key` are frozen.
  - On `block_valid && block_ready`: `block_valid` goes to 0 and the state returns to IDLE.
- **abort:** returns to IDLE from any state, clears the counter, and drops `block_valid`. `key` and `key_valid` are retained.
- **err_clear:** zeroes all three error flags. If a new error occurs in the same cycle, the flag is set (set wins).
- **Reset values:**
  - 0: `plain_text`, `key`, `key_valid`, `block_valid`, all error flags.
  - 1: `in_ready`.
  - State IDLE, counter 0.

## Timing
- **Block latency:** 8th data byte accepted at edge N → `block_valid` high after edge N. The core output settles combinationally within the same cycle.
- **Handshake:** `block_ready` is ignored while `block_valid`=0. The handshake completes at the edge where both are high.
- **Bubble after a block:** `in_ready` is low for every HOLD cycle. There is one bubble cycle minimum per data block; the next byte is accepted at the edge following the handshake at the earliest.
- **Key commit:** `key` changes at the edge accepting the 8th key byte. A key update cannot occur during HOLD.
- **Throughput:** back-to-back bytes with `in_valid` held high: 8 accept cycles plus ≥1 HOLD cycle per block.
- **Asynchronous reset mid-group or mid-HOLD:** all state clears immediately; the partial data is lost.

## Structure
- Shared package `des_pkg`:
  - state enum `loader_state_t` {IDLE, COLLECT, HOLD};
  - constant `DES_BLOCK_BYTES`=8;
  - constant `DES_BLOCK_BITS`=64.
- Single module with no sub-module. The odd-parity check is an 8-input XOR reduction per byte, accumulated into a 1-bit "parity bad" flag across the group.

## Test plan
- **Key then data:** key bytes 13 34 57 79 9B BC DF F1, then data 01 23 45 67 89 AB CD EF, with `block_ready`=1 → `key`=133457799BBCDFF1, `plain_text`=0123456789ABCDEF, `block_valid` high for 1 cycle; core `encrypted`=85E813540F0AB405.
- **Data before any key:** 8 data bytes → no `block_valid`, `err_no_key`=1, `in_ready` stays 1; a subsequent `err_clear` → flag 0.
- **Tag flip:** 3 data bytes, then 8 key bytes → `err_mismatch`=1 and the key is committed from the 8 key bytes, with the first key byte at bits 63:56.
- **Backpressure:** `block_ready`=0 for 5 cycles after `block_valid` → `in_ready`=0 and `plain_text` stable throughout; `block_ready`=1 → IDLE on the next edge.
- **Parity check:** `CHECK_PARITY`=1 with key byte 12 (even parity) → `err_parity`=1, `key` unchanged, `key_valid` unchanged.
- **Abort and reset:** `abort` during HOLD → `block_valid`=0 and the key is retained. `rst` pulse mid-group → all outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/des_pkg.sv
// Shared definitions for the DES byte-serial front end.
//   loader_state_t  : loader FSM state encoding
//   DES_BLOCK_BYTES : bytes per key or plaintext group
//   DES_BLOCK_BITS  : width of a DES key / block
//   odd_parity()    : 1 when a byte carries an odd number of ones
package des_pkg;

  localparam int unsigned DES_BLOCK_BYTES = 8;
  localparam int unsigned DES_BLOCK_BITS  = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } loader_state_t;

  function automatic logic odd_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/des_block_loader.sv
// Byte-serial front end for the combinational DES core. Bytes tagged as key or
// plaintext are shifted MSB-first into a shadow register; a complete key group
// is committed to `key`, a complete plaintext group is presented on `plain_text`
// and held under a valid/ready handshake until the capture stage takes it.
//
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : byte handshake; in_data byte, in_is_key tag (1 = key)
//   abort               : synchronous flush of partial group / held block
//   err_clear           : synchronous clear of the sticky error flags
//   plain_text, key     : to core plainText / key (first byte in bits 63:56)
//   key_valid           : a key has been committed since reset
//   block_valid/ready   : plaintext block handshake toward the capture stage
//   err_mismatch        : sticky, tag changed inside a group
//   err_no_key          : sticky, data block completed with no key
//   err_parity          : sticky, key group rejected for even-parity byte
module des_block_loader
  import des_pkg::*;
#(
  parameter bit CHECK_PARITY = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [7:0]                in_data,
  input  logic                      in_is_key,
  output logic                      in_ready,
  input  logic                      abort,
  input  logic                      err_clear,
  output logic [DES_BLOCK_BITS-1:0] plain_text,
  output logic [DES_BLOCK_BITS-1:0] key,
  output logic                      key_valid,
  output logic                      block_valid,
  input  logic                      block_ready,
  output logic                      err_mismatch,
  output logic                      err_no_key,
  output logic                      err_parity
);

  localparam logic [2:0] LastIdx = 3'(DES_BLOCK_BYTES - 1);

  loader_state_t             state_q, state_d;
  logic [2:0]                cnt_q, cnt_d;
  logic                      grp_key_q, grp_key_d;
  logic [DES_BLOCK_BITS-1:0] shadow_q, shadow_d;
  logic                      par_bad_q, par_bad_d;
  logic [DES_BLOCK_BITS-1:0] key_q, key_d;
  logic [DES_BLOCK_BITS-1:0] pt_q, pt_d;
  logic                      key_valid_q, key_valid_d;
  logic                      block_valid_q, block_valid_d;
  logic                      err_mm_q, err_mm_d;
  logic                      err_nk_q, err_nk_d;
  logic                      err_par_q, err_par_d;

  logic                      accept;
  logic                      mismatch;
  logic                      new_group;
  logic                      last_byte;
  logic                      key_done;
  logic                      data_done;
  logic                      byte_even;
  logic                      group_par_bad;
  logic                      commit_key;
  logic                      present_block;
  logic                      handshake;
  logic [DES_BLOCK_BITS-1:0] shifted;

  // Decode of the current byte transfer.
  assign accept    = in_valid && in_ready;
  assign mismatch  = accept && (state_q == COLLECT) && (in_is_key != grp_key_q);
  // A mismatching byte starts a fresh group of its own type.
  assign new_group = accept && ((state_q == IDLE) || mismatch);
  assign last_byte = accept && !new_group && (cnt_q == LastIdx);
  assign key_done  = last_byte && grp_key_q;
  assign data_done = last_byte && !grp_key_q;
  assign shifted   = {shadow_q[DES_BLOCK_BITS-9:0], in_data};

  // Parity of the whole group is the OR of per-byte "even" flags.
  assign byte_even     = !odd_parity(in_data);
  assign group_par_bad = CHECK_PARITY && (par_bad_q || byte_even);
  assign commit_key    = key_done && !group_par_bad;
  assign present_block = data_done && key_valid_q;
  assign handshake     = block_valid_q && block_ready;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 3'd0;
      grp_key_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      grp_key_q <= grp_key_d;
    end
  end

  // FSM next-state logic; cnt counts bytes currently held in the group.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    grp_key_d = grp_key_q;
    if (abort) begin
      state_d = IDLE;
      cnt_d   = 3'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_d   = COLLECT;
            cnt_d     = 3'd1;
            grp_key_d = in_is_key;
          end
        end
        COLLECT: begin
          if (mismatch) begin
            cnt_d     = 3'd1;
            grp_key_d = in_is_key;
          end else if (last_byte) begin
            cnt_d   = 3'd0;
            state_d = present_block ? HOLD : IDLE;
          end else if (accept) begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        HOLD: begin
          if (handshake) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = 3'd0;
        end
      endcase
    end
  end

  // FSM outputs.
  always_comb begin
    in_ready = (state_q != HOLD) && !abort;
  end

  // Datapath and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q      <= '0;
      par_bad_q     <= 1'b0;
      key_q         <= '0;
      pt_q          <= '0;
      key_valid_q   <= 1'b0;
      block_valid_q <= 1'b0;
      err_mm_q      <= 1'b0;
      err_nk_q      <= 1'b0;
      err_par_q     <= 1'b0;
    end else begin
      shadow_q      <= shadow_d;
      par_bad_q     <= par_bad_d;
      key_q         <= key_d;
      pt_q          <= pt_d;
      key_valid_q   <= key_valid_d;
      block_valid_q <= block_valid_d;
      err_mm_q      <= err_mm_d;
      err_nk_q      <= err_nk_d;
      err_par_q     <= err_par_d;
    end
  end

  always_comb begin
    shadow_d      = shadow_q;
    par_bad_d     = par_bad_q;
    key_d         = key_q;
    pt_d          = pt_q;
    key_valid_d   = key_valid_q;
    block_valid_d = block_valid_q;

    // Stale bytes of a discarded group simply shift out before completion.
    if (accept) begin
      shadow_d  = shifted;
      par_bad_d = new_group ? byte_even : (par_bad_q || byte_even);
    end

    if (commit_key) begin
      key_d       = shifted;
      key_valid_d = 1'b1;
    end

    if (present_block) begin
      pt_d = shifted;
    end

    if (abort) begin
      block_valid_d = 1'b0;
    end else if (present_block) begin
      block_valid_d = 1'b1;
    end else if (handshake) begin
      block_valid_d = 1'b0;
    end

    // Clear first so a same-cycle error still sets its flag.
    err_mm_d  = err_clear ? 1'b0 : err_mm_q;
    err_nk_d  = err_clear ? 1'b0 : err_nk_q;
    err_par_d = err_clear ? 1'b0 : err_par_q;
    if (mismatch)                    err_mm_d  = 1'b1;
    if (data_done && !key_valid_q)   err_nk_d  = 1'b1;
    if (key_done && group_par_bad)   err_par_d = 1'b1;
  end

  assign plain_text   = pt_q;
  assign key          = key_q;
  assign key_valid    = key_valid_q;
  assign block_valid  = block_valid_q;
  assign err_mismatch = err_mm_q;
  assign err_no_key   = err_nk_q;
  assign err_parity   = err_par_q;

endmodule
